// File: rtl/ctrl_bubble_stage_pkg.sv
// ctrl_bubble_stage_pkg: sequencer state type and control-bundle bit positions for the ID/EX stage
package ctrl_pkg;
  typedef enum logic {IDLE, SEQ} seq_state_e;
  localparam int CTRL_W_DEF = 9;
  localparam int REGDST_B = 8;
  localparam int ALUSRC_B = 7;
  localparam int MEMTOREG_B = 6;
  localparam int REGWRITE_B = 5;
  localparam int MEMWRITE_B = 4;
  localparam int EXTOP_B = 3;
  localparam int ALUOP_MSB = 2;
  localparam int ALUOP_LSB = 1;
  localparam int MEMREAD_B = 0;
endpackage

// File: rtl/ctrl_bubble_stage_if.sv
// ctrl_bubble_stage_if: decoder/hazard-side inputs and EX-side outputs; bubble_cnt_o exists only with CTRL_BUBBLE_STATS_EN
interface ctrl_bubble_stage_if #(
  parameter int CTRL_W = 9
`ifdef CTRL_BUBBLE_STATS_EN
  , parameter int STAT_W = 16
`endif
);
  logic [CTRL_W-1:0] ctrl_i;
  logic              hazard_i;
  logic              stall_i;
  logic              flush_i;
  logic [CTRL_W-1:0] ctrl_o;
  logic              valid_o;
  logic              busy_o;
`ifdef CTRL_BUBBLE_STATS_EN
  logic [STAT_W-1:0] bubble_cnt_o;
  modport master (output ctrl_i, hazard_i, stall_i, flush_i, input ctrl_o, valid_o, busy_o, bubble_cnt_o);
  modport slave (input ctrl_i, hazard_i, stall_i, flush_i, output ctrl_o, valid_o, busy_o, bubble_cnt_o);
`else
  modport master (output ctrl_i, hazard_i, stall_i, flush_i, input ctrl_o, valid_o, busy_o);
  modport slave (input ctrl_i, hazard_i, stall_i, flush_i, output ctrl_o, valid_o, busy_o);
`endif
endinterface

// File: rtl/ctrl_bubble_stage_seq.sv
// bubble_seq: turns one hazard pulse into BUBBLE_CYC bubble strobes, counting only unstalled edges
module bubble_seq import ctrl_pkg::*; #(
  parameter int BUBBLE_CYC = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic hazard_i,
  input  logic stall_i,
  input  logic flush_i,
  output logic busy_o,
  output logic insert_bubble_o
);
  localparam logic [3:0] CYC_M1 = 4'(BUBBLE_CYC - 1);
  seq_state_e state, state_n;
  logic [3:0] cnt, cnt_n;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  // hazard only matters in IDLE; in SEQ every unstalled, unflushed edge is a bubble
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    insert_bubble_o = !flush_i && !stall_i && (state == SEQ || hazard_i);
    if (state == SEQ && flush_i) begin
      state_n = IDLE;
      cnt_n = '0;
    end else if (insert_bubble_o) begin
      state_n = state == IDLE ? (BUBBLE_CYC > 1 ? SEQ : IDLE) : (cnt == 4'd1 ? IDLE : SEQ);
      cnt_n = state == IDLE ? CYC_M1 : cnt - 4'd1;
    end
  end
  assign busy_o = state == SEQ;
endmodule

// File: rtl/ctrl_bubble_stage.sv
// ctrl_bubble_stage: ID/EX control register with masked hazard bubbles, stall hold and flush
// Optional bubble statistics counter enabled by CTRL_BUBBLE_STATS_EN.
module ctrl_bubble_stage import ctrl_pkg::*; #(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter logic [CTRL_W-1:0] KEEP_MASK = '0,
  parameter int BUBBLE_CYC = 1
`ifdef CTRL_BUBBLE_STATS_EN
  , parameter int STAT_W = 16
`endif
) (
  input logic clk_i,
  input logic rst_i,
  ctrl_bubble_stage_if.slave bus
);
  logic insert_bubble;
  logic [CTRL_W-1:0] bubble;
  assign bubble = bus.ctrl_i & KEEP_MASK;
  bubble_seq #(.BUBBLE_CYC(BUBBLE_CYC)) u_seq (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .hazard_i(bus.hazard_i),
    .stall_i(bus.stall_i),
    .flush_i(bus.flush_i),
    .busy_o(bus.busy_o),
    .insert_bubble_o(insert_bubble)
  );
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      bus.ctrl_o <= '0;
      bus.valid_o <= 1'b0;
    end else if (bus.flush_i) begin
      bus.ctrl_o <= bubble;
      bus.valid_o <= 1'b0;
    end else if (!bus.stall_i) begin
      bus.ctrl_o <= insert_bubble ? bubble : bus.ctrl_i;
      bus.valid_o <= !insert_bubble;
    end
`ifdef CTRL_BUBBLE_STATS_EN
  // flush bubbles never raise insert_bubble, so they stay uncounted
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) bus.bubble_cnt_o <= '0;
    else if (insert_bubble && !(&bus.bubble_cnt_o)) bus.bubble_cnt_o <= bus.bubble_cnt_o + 1'b1;
`endif
endmodule

// File: tb/tb_ctrl_bubble_stage.sv
// tb_ctrl_bubble_stage: directed + random stimulus, reference model pushes expectations, monitor compares
module tb_ctrl_bubble_stage;
  localparam int W = 9;
  localparam logic [W-1:0] MASK = 9'h003;
  localparam int NB = 2;
  localparam int SW = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
`ifdef CTRL_BUBBLE_STATS_EN
  ctrl_bubble_stage_if #(.CTRL_W(W), .STAT_W(SW)) bus ();
  ctrl_bubble_stage #(.CTRL_W(W), .KEEP_MASK(MASK), .BUBBLE_CYC(NB), .STAT_W(SW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
`else
  ctrl_bubble_stage_if #(.CTRL_W(W)) bus ();
  ctrl_bubble_stage #(.CTRL_W(W), .KEEP_MASK(MASK), .BUBBLE_CYC(NB)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
`endif
  typedef struct {
    int ctrl;
    int valid;
    int busy;
    int stats;
  } exp_t;
  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;
  int m_ctrl, m_valid, m_pend, m_stats;
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // called at a falling edge: applies inputs and predicts the state after the next rising edge
  task automatic drive(input logic [W-1:0] c, input logic hz, input logic st, input logic fl);
    exp_t e;
    bus.ctrl_i = c;
    bus.hazard_i = hz;
    bus.stall_i = st;
    bus.flush_i = fl;
    if (fl) begin
      m_ctrl = int'(c & MASK);
      m_valid = 0;
      m_pend = 0;
    end else if (!st) begin
      if (m_pend > 0 || hz) begin
        m_ctrl = int'(c & MASK);
        m_valid = 0;
        m_pend = m_pend > 0 ? m_pend - 1 : NB - 1;
        m_stats = m_stats + 1 > (1 << SW) - 1 ? (1 << SW) - 1 : m_stats + 1;
      end else begin
        m_ctrl = int'(c);
        m_valid = 1;
      end
    end
    e.ctrl = m_ctrl;
    e.valid = m_valid;
    e.busy = m_pend > 0 ? 1 : 0;
    e.stats = m_stats;
    q.push_back(e);
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.ctrl_i = '0;
    bus.hazard_i = 1'b0;
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    #1;
    chk("rst_ctrl", int'(bus.ctrl_o), 0);
    chk("rst_valid", int'(bus.valid_o), 0);
    chk("rst_busy", int'(bus.busy_o), 0);
`ifdef CTRL_BUBBLE_STATS_EN
    chk("rst_stats", int'(bus.bubble_cnt_o), 0);
`endif
    m_ctrl = 0;
    m_valid = 0;
    m_pend = 0;
    m_stats = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ctrl_o", int'(bus.ctrl_o), e.ctrl);
        chk("valid_o", int'(bus.valid_o), e.valid);
        chk("busy_o", int'(bus.busy_o), e.busy);
`ifdef CTRL_BUBBLE_STATS_EN
        chk("bubble_cnt_o", int'(bus.bubble_cnt_o), e.stats);
`endif
      end
    end
  end
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin : stim
    bus.ctrl_i = '0;
    bus.hazard_i = 1'b0;
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    @(negedge clk);
    do_reset();
    drive(9'h1A5, 0, 0, 0);
    drive(9'h1FF, 1, 0, 0);
    drive(9'h1FF, 0, 0, 0);
    drive(9'h1FF, 0, 0, 0);
    drive(9'h0F3, 1, 0, 0);
    drive(9'h0F3, 0, 0, 0);
    drive(9'h0F3, 0, 0, 0);
    drive(9'h0A2, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive(9'h0A2, 0, 1, 0);
    drive(9'h0A2, 0, 0, 0);
    drive(9'h0A2, 0, 0, 0);
    drive(9'h1FF, 1, 0, 1);
    drive(9'h155, 0, 0, 0);
    drive(9'h0AB, 1, 0, 0);
    drive(9'h0AB, 1, 0, 1);
    drive(9'h0AB, 0, 0, 0);
    drive(9'h0C7, 1, 1, 0);
    drive(9'h0C7, 1, 0, 0);
    drive(9'h0C7, 0, 0, 0);
    drive(9'h0C7, 1, 0, 0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(9'h1F0, 1, 0, 0);
      drive(9'h1F0, 0, 0, 0);
    end
    drive(9'h1F1, 0, 0, 1);
    drive(9'h1F1, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) == 0) do_reset();
      else drive(W'($urandom), $urandom_range(3) == 0, $urandom_range(4) == 0, $urandom_range(9) == 0);
    end
    drive(9'h000, 0, 0, 0);
    @(negedge clk);
    chk("drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ctrl_bubble_stage.md
Name: ctrl_bubble_stage

Overview:
- Parametrised ID/EX control-bundle pipeline register with built-in hazard bubble insertion, stall hold and flush.
- Generalises the combinational hazard zeroing mux to any control width and a per-bit keep mask.
- Adds a multi-cycle bubble sequencer, so one hazard pulse inserts BUBBLE_CYC consecutive bubbles.
- Sits between the decoder/hazard unit and the EX stage and drives the registered control bundle into EX.

Parameters:
- CTRL_W, 9, width of control bundle (RegDst, ALUSrc, MemtoReg, RegWrite, MemWrite, ExtOp, ALUOp[1:0], MemRead).
- KEEP_MASK, {CTRL_W{1'b0}}, bits set here pass ctrl_i through during a bubble; cleared bits are forced to 0.
- BUBBLE_CYC, 1, number of bubbles per hazard event; legal range 1..15.
- STAT_W, 16, width of the optional bubble statistics counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-high reset.
- ctrl_i  in  CTRL_W  decoded control bundle from ID.
- hazard_i  in  1  hazard detected; request bubble insertion.
- stall_i  in  1  downstream stall; hold register contents.
- flush_i  in  1  branch/jump flush; kill current entry.
- ctrl_o  out  CTRL_W  registered control bundle to EX.
- valid_o  out  1  ctrl_o carries a real instruction (0 = bubble).
- busy_o  out  1  sequencer inserting follow-on bubbles; upstream must hold PC/IF-ID.
- bubble_cnt_o  out  STAT_W  bubbles inserted; present only with CTRL_BUBBLE_STATS_EN.

Behaviour:
- Reset, asynchronous: ctrl_o=0, valid_o=0, state=IDLE, cnt=0, bubble_cnt_o=0. Reset mid-sequence aborts the sequence immediately.
- Bubble value = ctrl_i & KEEP_MASK.
- States are IDLE and SEQ. cnt is 4 bits and holds the remaining bubbles.
- Per-edge priority: flush_i > stall_i > sequencer/hazard > normal load.
- IDLE:
  - flush_i: load bubble, valid_o=0, stay IDLE.
  - stall_i: hold ctrl_o and valid_o.
  - hazard_i: load bubble, valid_o=0. If BUBBLE_CYC>1: cnt=BUBBLE_CYC-1 and go to SEQ; otherwise stay IDLE.
  - Otherwise: ctrl_o=ctrl_i, valid_o=1.
- SEQ:
  - flush_i: load bubble, cnt=0, go to IDLE.
  - stall_i: hold everything, cnt unchanged.
  - Otherwise: load bubble, cnt=cnt-1; when cnt was 1, go to IDLE.
  - hazard_i is ignored in SEQ; no re-trigger or extension.
- busy_o = (state==SEQ), decoded from registered state only, no combinational path from inputs.
- Latency: ctrl_i to ctrl_o is one cycle.
- Hazard rising in cycle N gives bubbles at edges N..N+BUBBLE_CYC-1, counting only unstalled edges.
- Simultaneous hazard_i and stall_i in IDLE: stall wins. Hazard is re-sampled on the next edge, so the hazard unit must hold hazard_i.
- BUBBLE_CYC=1: behaviour is equivalent to the old zeroing mux followed by a plain register; SEQ is never entered.

Optional Feature:
- Macro: CTRL_BUBBLE_STATS_EN.
- Defined:
  - bubble_cnt_o increments by 1 on every unstalled edge that loads a bubble due to a hazard or SEQ.
  - Flush and reset bubbles are not counted.
  - Saturates at all-ones and is reset to 0 by rst_i.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package ctrl_pkg:
  - State enum (IDLE, SEQ).
  - Control-bundle bit-index constants (REGDST_B, ALUSRC_B, MEMTOREG_B, REGWRITE_B, MEMWRITE_B, EXTOP_B, ALUOP_LSB/MSB, MEMREAD_B).
  - Default CTRL_W.
- One natural sub-module: bubble_seq, holding state, cnt and busy_o, and emitting an insert_bubble strobe.
- The top level holds the data register, mask logic and optional statistics counter.

Test Plan (CTRL_W=9, KEEP_MASK=0, BUBBLE_CYC=2 unless noted):
- Pass-through: rst_i pulse, then ctrl_i=9'h1A5, no hazard → next edge ctrl_o=9'h1A5, valid_o=1; during reset ctrl_o=0, valid_o=0.
- Hazard: ctrl_i=9'h1FF, hazard_i for 1 cycle → two edges give ctrl_o=0, valid_o=0; busy_o=1 for exactly 1 cycle; third edge ctrl_o=9'h1FF.
- Keep mask: KEEP_MASK=9'h003, ctrl_i=9'h0F3, hazard_i → ctrl_o=9'h003, valid_o=0.
- Stall in SEQ: hazard, then stall_i high 3 cycles during SEQ → ctrl_o held at 0, busy_o stays 1, 2nd bubble follows stall release, then normal load.
- Flush priority and reset abort: flush_i together with hazard_i in IDLE → bubble, stays IDLE, busy_o=0. Flush in SEQ → IDLE next edge. rst_i asserted mid-SEQ → busy_o=0 immediately.
- Stats (CTRL_BUBBLE_STATS_EN, STAT_W=2): 3 hazard events → bubble_cnt_o saturates at 3 after 6 bubbles. Flush bubbles leave it unchanged.
